// File: rtl/spi_frame_decoder_if.sv
// Bus bundle between the SPI byte engine and its neighbours.
// SPI side : ss, rx_data, rx_rdy (toward decoder); tx_data, tx_latch (toward SPI slave)
// CSR side : csr_addr, csr_wdata, csr_we, csr_re (toward CSR); csr_rdata (toward decoder)
// master   : the frame decoder; slave : the SPI slave plus CSR block around it.
interface spi_frame_decoder_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              ss;
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic [7:0]        tx_data;
  logic              tx_latch;
  logic [ADDR_W-1:0] csr_addr;
  logic [7:0]        csr_wdata;
  logic              csr_we;
  logic              csr_re;
  logic [7:0]        csr_rdata;

  modport master (
    input  ss, rx_data, rx_rdy, csr_rdata,
    output tx_data, tx_latch, csr_addr, csr_wdata, csr_we, csr_re
  );

  modport slave (
    output ss, rx_data, rx_rdy, csr_rdata,
    input  tx_data, tx_latch, csr_addr, csr_wdata, csr_we, csr_re
  );
endinterface

// File: rtl/spi_frame_decoder.sv
// Byte-level frame engine between an SPI slave and a CSR block.
// A frame is bounded by slave-select low. The first byte is a header
// (bit7 = write, bits[6:0] = start address); following bytes are write data
// or dummy bytes that clock out auto-incrementing read data.
// Ports: sys_clk, rst (async active-low), bus (master modport: SPI byte
// stream in, tx byte out, CSR strobes), busy (frame in progress),
// err (sticky out-of-range flag).
module spi_frame_decoder #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter logic [7:0]  RD_FILL  = 8'hFF
) (
  input  logic                sys_clk,
  input  logic                rst,
  spi_frame_decoder_if.master bus,
  output logic                busy,
  output logic                err
);

  localparam int unsigned HDR_AW = 7;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMP_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WR,
    S_RD_FETCH,
    S_RD_LOAD,
    S_RD_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic                ss_meta_q, ss_meta_d;
  logic                ss_s_q, ss_s_d;
  logic                ss_prev_q, ss_prev_d;
  logic [HDR_AW-1:0]   addr_q, addr_d;
  logic                bad_q, bad_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_latch_q, tx_latch_d;
  logic [ADDR_W-1:0]   csr_addr_q, csr_addr_d;
  logic [BYTE_W-1:0]   csr_wdata_q, csr_wdata_d;
  logic                csr_we_q, csr_we_d;
  logic                csr_re_q, csr_re_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [HDR_AW-1:0]   hdr_addr;
  logic                hdr_bad;
  logic                ss_fall;

  // Wrap from the last implemented register back to 0.
  function automatic logic [HDR_AW-1:0] addr_inc(input logic [HDR_AW-1:0] a);
    if (CMP_W'({1'b0, a}) == CMP_W'(NUM_REGS - 1)) begin
      return '0;
    end
    return a + HDR_AW'(1);
  endfunction

  assign hdr_addr = bus.rx_data[HDR_AW-1:0];
  // 8-bit compare so NUM_REGS = 128 still works.
  assign hdr_bad  = CMP_W'({1'b0, hdr_addr}) >= CMP_W'(NUM_REGS);
  assign ss_fall  = ss_prev_q & ~ss_s_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ss_meta_d   = bus.ss;
    ss_s_d      = ss_meta_q;
    ss_prev_d   = ss_s_q;
    addr_d      = addr_q;
    bad_d       = bad_q;
    tx_data_d   = tx_data_q;
    tx_latch_d  = 1'b0;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    csr_we_d    = 1'b0;
    csr_re_d    = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (ss_fall) begin
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        if (bus.rx_rdy) begin
          addr_d = hdr_addr;
          bad_d  = hdr_bad;
          if (hdr_bad) begin
            err_d = 1'b1;
          end
          if (ss_s_q) begin
            // Frame closing with the header: no fetch is started.
            state_d = S_IDLE;
          end else if (bus.rx_data[BYTE_W-1]) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD_FETCH;
            if (!hdr_bad) begin
              csr_re_d   = 1'b1;
              csr_addr_d = ADDR_W'(hdr_addr);
            end
          end
        end else if (ss_s_q) begin
          state_d = S_IDLE;
        end
      end

      S_WR: begin
        // A byte landing together with ss rising still commits.
        if (bus.rx_rdy && !bad_q) begin
          csr_we_d    = 1'b1;
          csr_wdata_d = bus.rx_data;
          csr_addr_d  = ADDR_W'(addr_q);
          addr_d      = addr_inc(addr_q);
        end
        if (ss_s_q) begin
          state_d = S_IDLE;
        end
      end

      S_RD_FETCH: begin
        state_d = ss_s_q ? S_IDLE : S_RD_LOAD;
      end

      S_RD_LOAD: begin
        if (ss_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_RD_WAIT;
          tx_data_d  = bad_q ? RD_FILL : bus.csr_rdata;
          tx_latch_d = 1'b1;
          if (!bad_q) begin
            addr_d = addr_inc(addr_q);
          end
        end
      end

      S_RD_WAIT: begin
        if (ss_s_q) begin
          state_d = S_IDLE;
        end else if (bus.rx_rdy) begin
          state_d = S_RD_FETCH;
          if (!bad_q) begin
            csr_re_d   = 1'b1;
            csr_addr_d = ADDR_W'(addr_q);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ss_meta_q   <= 1'b1;
      ss_s_q      <= 1'b1;
      ss_prev_q   <= 1'b1;
      addr_q      <= '0;
      bad_q       <= 1'b0;
      tx_data_q   <= '0;
      tx_latch_q  <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_we_q    <= 1'b0;
      csr_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_meta_q   <= ss_meta_d;
      ss_s_q      <= ss_s_d;
      ss_prev_q   <= ss_prev_d;
      addr_q      <= addr_d;
      bad_q       <= bad_d;
      tx_data_q   <= tx_data_d;
      tx_latch_q  <= tx_latch_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      csr_we_q    <= csr_we_d;
      csr_re_q    <= csr_re_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_latch  = tx_latch_q;
  assign bus.csr_addr  = csr_addr_q;
  assign bus.csr_wdata = csr_wdata_q;
  assign bus.csr_we    = csr_we_q;
  assign bus.csr_re    = csr_re_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Bench for spi_frame_decoder: random frames scored against a cycle-scheduled
// frame-level model, plus directed frames with hand-computed expectations.
module tb_spi_frame_decoder;

  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam int          NEVER = 2147483647;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;

  spi_frame_decoder_if #(.ADDR_W(AW)) bus ();

  spi_frame_decoder #(.NUM_REGS(NREG), .ADDR_W(AW), .RD_FILL(8'hFF)) dut (
    .sys_clk (clk),
    .rst     (rst_n),
    .bus     (bus.master),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Expected events keyed by the cycle they must be visible in.
  logic [11:0] exp_we  [int];
  logic [3:0]  exp_re  [int];
  logic [7:0]  exp_lat [int];
  bit          exp_busy[int];
  int          err_from = NEVER;

  logic [7:0] tx_model;
  int         we_cnt = 0;
  int         re_cnt = 0;
  logic [7:0] lat_dat[$];
  int         lat_cyc[$];
  int         last_hdr_cyc = 0;

  logic [7:0] csr_mem [16] = '{default: 8'h00};
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  logic [7:0] rdata_q = 8'h00;
  logic [7:0] fr_data [4];

  // CSR block: registered read data, one cycle after csr_re.
  always @(posedge clk) begin
    if (bus.csr_we) csr_mem[bus.csr_addr] <= bus.csr_wdata;
    if (bus.csr_re) rdata_q <= csr_mem[bus.csr_addr];
  end
  assign bus.csr_rdata = rdata_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare process: every cycle against the scheduled model.
  always @(negedge clk) begin
    if (!rst_n) tx_model = 8'h00;
    if (bus.csr_we) we_cnt++;
    if (bus.csr_re) re_cnt++;
    if (bus.tx_latch) begin
      lat_dat.push_back(bus.tx_data);
      lat_cyc.push_back(cyc);
    end
    if (chk_en) begin
      if (exp_we.exists(cyc)) begin
        chk("csr_we", 32'(bus.csr_we), 32'd1);
        chk("we_addr", 32'(bus.csr_addr), 32'(exp_we[cyc][11:8]));
        chk("we_data", 32'(bus.csr_wdata), 32'(exp_we[cyc][7:0]));
      end else begin
        chk("csr_we_idle", 32'(bus.csr_we), 32'd0);
      end
      if (exp_re.exists(cyc)) begin
        chk("csr_re", 32'(bus.csr_re), 32'd1);
        chk("re_addr", 32'(bus.csr_addr), 32'(exp_re[cyc]));
      end else begin
        chk("csr_re_idle", 32'(bus.csr_re), 32'd0);
      end
      if (exp_lat.exists(cyc)) begin
        tx_model = exp_lat[cyc];
        chk("tx_latch", 32'(bus.tx_latch), 32'd1);
      end else begin
        chk("tx_latch_idle", 32'(bus.tx_latch), 32'd0);
      end
      chk("tx_data", 32'(bus.tx_data), 32'(tx_model));
      chk("busy", 32'(busy), 32'(exp_busy.exists(cyc)));
      chk("err", 32'(err), 32'(cyc >= err_from));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plan one frame: ss falls now, header 4 cycles later, ss rises 'tail'
  // cycles after the last byte. Expectations are scheduled, then driven.
  task automatic run_frame(input logic [7:0] hdr, input int nb, input int tail, input bit empty);
    int t[$];
    logic [7:0] b[$];
    int f, e, a, c;
    bit bad, wr;
    bus.ss = 1'b0;
    f = cyc;
    wr = hdr[7];
    if (empty) begin
      e = f + 4 + int'($urandom_range(0, 3));
    end else begin
      t.push_back(f + 4);
      b.push_back(hdr);
      for (int i = 0; i < nb; i++) begin
        t.push_back(t[t.size()-1] + int'(wr ? $urandom_range(1, 3) : $urandom_range(3, 5)));
        b.push_back(wr ? fr_data[i] : 8'($urandom));
      end
      e = t[t.size()-1] + tail;
    end
    for (int k = f + 3; k <= e + 2; k++) exp_busy[k] = 1'b1;

    if (!empty) begin
      a = int'(hdr[6:0]);
      bad = (a >= int'(NREG));
      last_hdr_cyc = t[0];
      if (bad && err_from > t[0] + 1) err_from = t[0] + 1;
      if (wr) begin
        for (int i = 1; i <= nb; i++) begin
          if (!bad) begin
            exp_we[t[i] + 1] = {4'(a), b[i]};
            ref_mem[a] = b[i];
            a = (a + 1) % int'(NREG);
          end
        end
      end else begin
        for (int i = 0; i <= nb; i++) begin
          c = t[i];
          if (!bad) exp_re[c + 1] = 4'(a);
          if (e >= c + 1) exp_lat[c + 3] = bad ? 8'hFF : ref_mem[a];
          if (!bad) a = (a + 1) % int'(NREG);
        end
      end
    end

    for (int k = f; k <= e + 5; k++) begin
      if (k != f) tick();
      bus.ss = (k >= e);
      bus.rx_rdy = 1'b0;
      for (int j = 0; j < t.size(); j++) begin
        if (t[j] == k) begin
          bus.rx_rdy = 1'b1;
          bus.rx_data = b[j];
        end
      end
      if (k == e + 3) begin
        bus.rx_rdy = 1'b1;
        bus.rx_data = 8'($urandom);
      end
    end
    bus.rx_rdy = 1'b0;
  endtask

  task automatic rand_frames(input int n);
    logic [7:0] h;
    for (int i = 0; i < n; i++) begin
      h = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 23))};
      for (int j = 0; j < 4; j++) fr_data[j] = 8'($urandom);
      run_frame(h, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int we0, re0, lat0;
    bus.ss = 1'b1;
    bus.rx_rdy = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) tick();
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_strobes", 32'({bus.csr_we, bus.csr_re, bus.tx_latch}), 32'd0);
    chk("rst_addr", 32'(bus.csr_addr), 32'd0);
    chk("rst_wdata", 32'(bus.csr_wdata), 32'd0);
    chk("rst_busy_err", 32'({busy, err}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();

    // Single write 0x83, 0x5A.
    we0 = we_cnt;
    fr_data[0] = 8'h5A;
    run_frame(8'h83, 1, 2, 1'b0);
    chk("wr_mem3", 32'(csr_mem[3]), 32'h5A);
    chk("wr_count", 32'(we_cnt - we0), 32'd1);
    chk("wr_busy_after", 32'(busy), 32'd0);

    // Burst write wrapping 15 -> 0 -> 1.
    fr_data[0] = 8'h11; fr_data[1] = 8'h22; fr_data[2] = 8'h33;
    run_frame(8'h8F, 3, 1, 1'b0);
    chk("wrap_mem15", 32'(csr_mem[15]), 32'h11);
    chk("wrap_mem0", 32'(csr_mem[0]), 32'h22);
    chk("wrap_mem1", 32'(csr_mem[1]), 32'h33);

    // Preload 2/3, then read burst from 2 with two dummy bytes.
    fr_data[0] = 8'hC4; fr_data[1] = 8'h7E;
    run_frame(8'h82, 2, 1, 1'b0);
    lat0 = lat_dat.size();
    run_frame(8'h02, 2, 2, 1'b0);
    chk("rd_latch_count", 32'(lat_dat.size() - lat0), 32'd3);
    if (lat_dat.size() >= lat0 + 2) begin
      chk("rd_first", 32'(lat_dat[lat0]), 32'hC4);
      chk("rd_second", 32'(lat_dat[lat0 + 1]), 32'h7E);
      chk("rd_latency", 32'(lat_cyc[lat0] - last_hdr_cyc), 32'd3);
    end

    // Out-of-range write then read.
    we0 = we_cnt;
    fr_data[0] = 8'h66;
    run_frame(8'h94, 1, 2, 1'b0);
    chk("oor_no_we", 32'(we_cnt - we0), 32'd0);
    chk("oor_err", 32'(err), 32'd1);
    re0 = re_cnt;
    lat0 = lat_dat.size();
    run_frame(8'h25, 0, 2, 1'b0);
    chk("oor_no_re", 32'(re_cnt - re0), 32'd0);
    chk("oor_fill_count", 32'(lat_dat.size() - lat0), 32'd1);
    if (lat_dat.size() > lat0) chk("oor_fill", 32'(lat_dat[lat0]), 32'hFF);
    chk("oor_err_sticky", 32'(err), 32'd1);

    // Abort: ss rises with the read header, fetch must not load.
    lat0 = lat_dat.size();
    run_frame(8'h05, 0, 0, 1'b0);
    chk("abort_no_latch", 32'(lat_dat.size() - lat0), 32'd0);
    fr_data[0] = 8'h99;
    run_frame(8'h84, 1, 2, 1'b0);
    chk("after_abort_mem4", 32'(csr_mem[4]), 32'h99);

    // Empty frame.
    we0 = we_cnt; re0 = re_cnt;
    run_frame(8'h00, 0, 0, 1'b1);
    chk("empty_no_strobe", 32'((we_cnt - we0) + (re_cnt - re0)), 32'd0);

    rand_frames(40);

    // Reset in the middle of a write frame.
    chk_en = 1'b0;
    bus.ss = 1'b0;
    repeat (4) tick();
    bus.rx_rdy = 1'b1;
    bus.rx_data = 8'h81;
    tick();
    bus.rx_rdy = 1'b0;
    repeat (2) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("mid_rst_strobes", 32'({bus.csr_we, bus.csr_re, bus.tx_latch}), 32'd0);
    chk("mid_rst_addr_wdata", 32'({bus.csr_addr, bus.csr_wdata}), 32'd0);
    chk("mid_rst_busy_err", 32'({busy, err}), 32'd0);
    we0 = we_cnt; re0 = re_cnt; lat0 = lat_dat.size();
    bus.ss = 1'b1;
    tick();
    bus.rx_rdy = 1'b1;
    bus.rx_data = 8'h55;
    tick();
    bus.rx_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    err_from = NEVER;
    tick();
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rx_rdy = 1'b1;
      bus.rx_data = 8'($urandom);
      tick();
      bus.rx_rdy = 1'b0;
      tick();
    end
    chk("post_rst_no_strobe", 32'((we_cnt - we0) + (re_cnt - re0) + (lat_dat.size() - lat0)), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();

    rand_frames(8);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
